// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and requester encodings for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_I = 2'd1,
    MEM_D = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Round-robin pointer values: the pointer names the requester that wins a tie
  localparam logic REQ_I = 1'b1;
  localparam logic REQ_D = 1'b0;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - saturating cycle counter that flags a hung memory transaction
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;

  // Count cycles spent waiting on memory; hold at TIMEOUT, restart when cleared
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

  // Fires in the cycle whose increment brings the count to TIMEOUT, so the
  // transaction is dropped after exactly TIMEOUT cycles of mem_req_o
  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between icache fill and dcache fill/writeback
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_done_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              err_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  arb_state_t state_q;
  logic       rr_q;
  logic       wd_expire;
  logic       wd_en;
  logic       wd_clr;

  assign wd_en  = (state_q == MEM_I) || (state_q == MEM_D);
  assign wd_clr = (state_q == IDLE) || (state_q == DONE);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Grant, run and retire one memory transaction at a time; all outputs registered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rr_q        <= REQ_D;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      i_done_o    <= 1'b0;
      d_done_o    <= 1'b0;
      err_o       <= 1'b0;
      i_rdata_o   <= '0;
      d_rdata_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_req_i && (!i_req_i || (rr_q == REQ_D))) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            state_q     <= MEM_D;
          end else if (i_req_i) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= i_addr_i;
            mem_wdata_o <= '0;
            state_q     <= MEM_I;
          end
        end
        MEM_I, MEM_D: begin
          // A real ack wins over a coincident watchdog expiry: the data is valid
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state_q   <= DONE;
            if (state_q == MEM_I) begin
              i_done_o <= 1'b1;
              if (!mem_we_o) i_rdata_o <= mem_rdata_i;
            end else begin
              d_done_o <= 1'b1;
              if (!mem_we_o) d_rdata_o <= mem_rdata_i;
            end
          end else if (wd_expire) begin
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            state_q   <= DONE;
            if (state_q == MEM_I) i_done_o <= 1'b1;
            else                  d_done_o <= 1'b1;
          end
        end
        DONE: begin
          i_done_o <= 1'b0;
          d_done_o <= 1'b0;
          err_o    <= 1'b0;
          // Hand tie priority to whichever requester was not just served
          rr_q     <= d_done_o ? REQ_I : REQ_D;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o = (i_req_i | d_req_i) & ~(i_done_o | d_done_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 4;

  typedef struct {
    bit          is_i;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
  } req_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
    int          len;
  } mem_exp_t;

  typedef struct {
    bit          is_i;
    logic [15:0] rdata;
    bit          err;
  } done_exp_t;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          i_req_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic          i_done_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_done_o;
  logic [DW-1:0] d_rdata_o;
  logic          err_o;
  logic          stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          resp_ack = 1'b0;
  logic          stray_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;

  mem_exp_t  mem_q[$];
  mem_exp_t  resp_q[$];
  done_exp_t done_q[$];

  bit          prefer_d;
  logic [15:0] model_i_rd;
  logic [15:0] model_d_rd;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO),
    .TO_W    (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_done_o    (i_done_o),
    .i_rdata_o   (i_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_done_o    (d_done_o),
    .d_rdata_o   (d_rdata_o),
    .err_o       (err_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (resp_ack | stray_ack)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic void model_reset();
    prefer_d   = 1'b1;
    model_i_rd = '0;
    model_d_rd = '0;
    mem_q.delete();
    resp_q.delete();
    done_q.delete();
  endfunction

  // Reference: one transaction as the specification describes it
  function automatic void model_push(input req_t r);
    mem_exp_t  m;
    done_exp_t d;
    bit        timed_out;
    bit        eff_we;
    timed_out = (r.lat >= TMO);
    eff_we    = r.is_i ? 1'b0 : r.we;
    m.we    = eff_we;
    m.addr  = r.addr;
    m.wdata = r.wdata;
    m.rdata = r.rdata;
    m.lat   = r.lat;
    m.len   = timed_out ? TMO : r.lat + 1;
    if (!timed_out && !eff_we) begin
      if (r.is_i) model_i_rd = r.rdata;
      else        model_d_rd = r.rdata;
    end
    d.is_i  = r.is_i;
    d.rdata = r.is_i ? model_i_rd : model_d_rd;
    d.err   = timed_out;
    prefer_d = r.is_i;
    mem_q.push_back(m);
    resp_q.push_back(m);
    done_q.push_back(d);
  endfunction

  function automatic req_t rand_req(input bit is_i);
    req_t r;
    r.is_i  = is_i;
    r.we    = is_i ? 1'b0 : 1'($urandom_range(0, 1));
    r.addr  = 16'($urandom);
    r.wdata = 16'($urandom);
    r.rdata = 16'($urandom);
    r.lat   = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 2);
    return r;
  endfunction

  function automatic req_t mk(input bit is_i, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rdata, input int lat);
    req_t r;
    r.is_i = is_i; r.we = we; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.lat = lat;
    return r;
  endfunction

  task automatic drive(input req_t r, input bit drop_early);
    int cyc     = 0;
    bit got     = 0;
    bit dropped = 0;
    if (r.is_i) begin
      i_req_i = 1'b1; i_addr_i = r.addr;
    end else begin
      d_req_i = 1'b1; d_we_i = r.we; d_addr_i = r.addr; d_wdata_i = r.wdata;
    end
    while (!got && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (r.is_i ? i_done_o : d_done_o) begin
        got = 1;
      end else if (drop_early && !dropped && mem_req_o) begin
        @(posedge clk_i);
        #1;
        d_req_i   = 1'b0;
        d_addr_i  = ~d_addr_i;
        d_wdata_i = ~d_wdata_i;
        dropped   = 1;
      end
    end
    if (!got) fail_msg(r.is_i ? "i_done_timeout" : "d_done_timeout");
    @(posedge clk_i);
    #1;
    if (r.is_i) begin
      i_req_i = 1'b0; i_addr_i = 16'($urandom);
    end else begin
      d_req_i = 1'b0; d_we_i = 1'($urandom_range(0, 1));
      d_addr_i = 16'($urandom); d_wdata_i = 16'($urandom);
    end
  endtask

  // ir is the icache request, dr the dcache one; both are raised in the same cycle when two=1
  task automatic run_round(input req_t ir, input bit two, input req_t dr, input bit drop_early);
    if (two) begin
      if (prefer_d) begin model_push(dr); model_push(ir); end
      else          begin model_push(ir); model_push(dr); end
    end else begin
      model_push(ir);
    end
    @(posedge clk_i);
    #1;
    if (two) begin
      fork
        drive(ir, 1'b0);
        drive(dr, 1'b0);
      join
    end else begin
      drive(ir, drop_early);
    end
  endtask

  task automatic do_reset();
    sb_en   = 1'b0;
    rst_n_i = 1'b0;
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();
    sb_en = 1'b1;
  endtask

  // Memory responder: acks each transaction after its scheduled delay, never for timeouts
  initial begin
    bit       in_txn = 0;
    int       rcnt   = 0;
    mem_exp_t cur;
    cur.lat = 1000;
    forever begin
      @(posedge clk_i);
      #1;
      resp_ack    = 1'b0;
      mem_rdata_i = 16'($urandom);
      if (mem_req_o && sb_en) begin
        if (!in_txn) begin
          in_txn = 1;
          rcnt   = 0;
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else                   cur.lat = 1000;
        end
        if (rcnt == cur.lat) begin
          resp_ack    = 1'b1;
          mem_rdata_i = cur.rdata;
        end
        rcnt++;
      end else begin
        in_txn = 0;
      end
    end
  end

  // Memory-side monitor: request fields, stability while pending, request length
  initial begin
    bit       prev    = 0;
    bit       have_cm = 0;
    int       mlen    = 0;
    mem_exp_t cm;
    forever begin
      @(negedge clk_i);
      if (!sb_en) begin
        have_cm = 0;
      end else if (mem_req_o && !prev) begin
        if (mem_q.size() == 0) begin
          fail_msg("spurious_mem_req");
        end else begin
          cm = mem_q.pop_front();
          have_cm = 1;
          mlen = 1;
          chk("mem_addr", mem_addr_o, cm.addr);
          chk("mem_we", mem_we_o, cm.we);
          if (cm.we) chk("mem_wdata", mem_wdata_o, cm.wdata);
        end
      end else if (mem_req_o) begin
        mlen++;
        if (have_cm) chk("mem_addr_stable", mem_addr_o, cm.addr);
      end else if (prev && have_cm) begin
        chk("mem_req_len", mlen, cm.len);
        have_cm = 0;
      end
      prev = mem_req_o;
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse; also checks stall_o and err_o
  initial begin
    done_exp_t de;
    forever begin
      @(negedge clk_i);
      if (sb_en) begin
        if (i_done_o || d_done_o) begin
          chk("done_exclusive", {i_done_o, d_done_o} != 2'b11, 1);
          chk("stall_in_done", stall_o, 0);
          if (done_q.size() == 0) begin
            fail_msg("spurious_done");
          end else begin
            de = done_q.pop_front();
            chk("done_port", i_done_o, de.is_i);
            chk("done_err", err_o, de.err);
            if (de.is_i) chk("i_rdata", i_rdata_o, de.rdata);
            else         chk("d_rdata", d_rdata_o, de.rdata);
          end
        end else begin
          chk("stall", stall_o, i_req_i || d_req_i);
          chk("err_without_done", err_o, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    req_t ri;
    req_t rd;
    model_reset();
    do_reset();

    // Reset state
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_i_done", i_done_o, 0);
    chk("rst_d_done", d_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_i_rdata", i_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);

    // Single D read, then a D write that must leave d_rdata_o alone
    rd = mk(0, 0, 16'h0040, 16'h0000, 16'hBEEF, 2);
    run_round(rd, 0, rd, 0);
    chk("d_read_held", d_rdata_o, 16'hBEEF);
    rd = mk(0, 1, 16'h0100, 16'h1234, 16'h5555, 1);
    run_round(rd, 0, rd, 0);
    chk("d_write_keeps_rdata", d_rdata_o, 16'hBEEF);

    // Three simultaneous pairs out of reset
    do_reset();
    for (int n = 0; n < 3; n++) begin
      ri = mk(1, 0, 16'h1000 + 16'(n), 16'h0, 16'hA000 + 16'(n), n);
      rd = mk(0, 0, 16'h2000 + 16'(n), 16'h0, 16'hD000 + 16'(n), 2 - n);
      run_round(ri, 1, rd, 0);
    end

    // Icache read that memory never acknowledges
    ri = mk(1, 0, 16'h0ABC, 16'h0, 16'hFFFF, 99);
    run_round(ri, 0, ri, 0);
    chk("timeout_i_rdata_kept", i_rdata_o, 16'hA002);

    // D read whose requester drops req mid-transaction
    rd = mk(0, 0, 16'h0300, 16'h0, 16'h7E57, 2);
    run_round(rd, 0, rd, 1);

    // Stray ack while idle
    @(posedge clk_i); #1;
    stray_ack = 1'b1;
    @(posedge clk_i); #1;
    stray_ack = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      chk("stray_no_done", i_done_o | d_done_o, 0);
      chk("stray_no_req", mem_req_o, 0);
    end

    // Reset while a D transaction is outstanding
    sb_en = 1'b0;
    @(posedge clk_i); #1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 16'h0200;
    for (int c = 0; c < 10 && !mem_req_o; c++) @(negedge clk_i);
    chk("mr_req_up", mem_req_o, 1);
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    chk("mr_req_async_drop", mem_req_o, 0);
    d_req_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("mr_no_done", i_done_o | d_done_o, 0);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    model_reset();
    sb_en = 1'b1;
    ri = mk(1, 0, 16'h0444, 16'h0, 16'h4321, 1);
    run_round(ri, 0, ri, 0);

    // Randomized rounds against the model
    for (int n = 0; n < 40; n++) begin
      int k;
      ri = rand_req(1);
      rd = rand_req(0);
      k  = $urandom_range(0, 2);
      if (k == 0)      run_round(ri, 0, ri, 0);
      else if (k == 1) run_round(rd, 0, rd, 0);
      else             run_round(ri, 1, rd, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (10) @(posedge clk_i);
    chk("done_q_drained", done_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
